// File: rtl/dmem_lsu.sv
// Load/store unit between the core request port and a data memory with one-cycle read latency.
// Latency: store/error respond at T+1, load at T+2; one request in flight, response held until rsp_ready_i.
module dmem_lsu #(
    parameter int DMEM_ADDRW = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [DMEM_ADDRW-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [31:0]           mem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, size_q;
    logic        uns_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept, bad_shape, out_of_range, req_err;
    logic [31:0] lane, load_fmt;

    assign req_ready_o = (state_q == S_IDLE) & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // Illegal size is folded into the alignment check.
    always_comb begin
        case (req_size_i)
            2'd1:    bad_shape = req_addr_i[0];
            2'd2:    bad_shape = |req_addr_i[1:0];
            2'd3:    bad_shape = 1'b1;
            default: bad_shape = 1'b0;
        endcase
    end

    assign out_of_range = (req_addr_i >> (DMEM_ADDRW + 2)) != 32'd0;
    assign req_err      = bad_shape | out_of_range;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (req_we_i | req_err) ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory strobes exist only in the accept cycle, driven straight from the request.
    always_comb begin
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wstrb_o = 4'b0000;
        mem_wdata_o = 32'd0;
        mem_addr_o  = '0;
        if (accept && !req_err) begin
            mem_addr_o = req_addr_i[DMEM_ADDRW+1:2];
            if (req_we_i) begin
                mem_we_o = 1'b1;
                case (req_size_i)
                    2'd0: begin
                        mem_wdata_o = {4{req_wdata_i[7:0]}};
                        mem_wstrb_o = 4'b0001 << req_addr_i[1:0];
                    end
                    2'd1: begin
                        mem_wdata_o = {2{req_wdata_i[15:0]}};
                        mem_wstrb_o = req_addr_i[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        mem_wdata_o = req_wdata_i;
                        mem_wstrb_o = 4'b1111;
                    end
                endcase
            end else begin
                mem_re_o = 1'b1;
            end
        end
    end

    assign lane = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_fmt = {{24{lane[7] & ~uns_q}}, lane[7:0]};
            2'd1:    load_fmt = {{16{lane[15] & ~uns_q}}, lane[15:0]};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            off_q   <= req_addr_i[1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            rdata_q <= 32'd0;
            err_q   <= req_err;
        end else if (state_q == S_WAIT) begin
            rdata_q <= load_fmt;
        end
    end
endmodule
